// File: rtl/camera_timer_pkg.sv
// Shared constants, state encoding and the exposure-setting step rule for the
// camera exposure/readout timer.
package camera_timer_pkg;

    localparam int PRESCALE_DEF    = 4;
    localparam int EXP_MIN_DEF     = 2;
    localparam int EXP_MAX_DEF     = 30;
    localparam int EXP_DEFAULT_DEF = 2;
    localparam int READOUT_LEN     = 5;

    localparam int EXP_W = 5;
    localparam int RO_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } exp_state_t;

    // One saturating step of the exposure setting; opposing requests cancel.
    function automatic logic [EXP_W-1:0] exp_step(
        input logic [EXP_W-1:0] cur,
        input logic             up,
        input logic             down,
        input logic [EXP_W-1:0] lo,
        input logic [EXP_W-1:0] hi
    );
        exp_step = cur;
        if (up && !down && cur < hi) begin
            exp_step = cur + 5'd1;
        end else if (down && !up && cur > lo) begin
            exp_step = cur - 5'd1;
        end
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a button level: one-cycle pulse when the level
// goes high relative to the previous sampled value.
module edge_detect (
    input  logic clk,
    input  logic Reset,
    input  logic level,
    output logic pulse
);

    logic prev;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (Reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/exposure_timer.sv
// Exposure timer: button-adjustable exposure length counted in prescaled
// units, plus an independent fixed-length readout timer.
module exposure_timer
    import camera_timer_pkg::*;
#(
    parameter int PRESCALE    = PRESCALE_DEF,
    parameter int EXP_MIN     = EXP_MIN_DEF,
    parameter int EXP_MAX     = EXP_MAX_DEF,
    parameter int EXP_DEFAULT = EXP_DEFAULT_DEF
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Exp_increase,
    input  logic       Exp_decrease,
    input  logic       Start,
    input  logic       Start_ro,
    output logic       Ovf,
    output logic       Ovf5,
    output logic       Busy,
    output logic [4:0] Exp_time
);

    localparam int                PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [EXP_W-1:0]  EXP_LO     = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0]  EXP_HI     = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0]  EXP_INIT   = EXP_W'(EXP_DEFAULT);
    localparam logic [RO_W-1:0]   RO_LOAD    = RO_W'(READOUT_LEN);

    logic inc_pulse;
    logic dec_pulse;

    edge_detect u_inc_edge (
        .clk   (clk),
        .Reset (Reset),
        .level (Exp_increase),
        .pulse (inc_pulse)
    );

    edge_detect u_dec_edge (
        .clk   (clk),
        .Reset (Reset),
        .level (Exp_decrease),
        .pulse (dec_pulse)
    );

    exp_state_t       state, state_next;
    logic [PW-1:0]    presc, presc_next;
    logic [EXP_W-1:0] units, units_next;
    logic             ovf_next;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        presc_next = presc;
        units_next = units;
        ovf_next   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    units_next = Exp_time;
                    presc_next = '0;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (presc == PRESC_LAST) begin
                    presc_next = '0;
                    units_next = units - 5'd1;
                    if (units <= 5'd1) begin
                        ovf_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    presc_next = presc + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
            presc <= '0;
            units <= '0;
            Ovf   <= 1'b0;
        end else begin
            state <= state_next;
            presc <= presc_next;
            units <= units_next;
            Ovf   <= ovf_next;
        end
    end

    assign Busy = (state == COUNT);

    // A Start in the same cycle wins: the count takes the old setting and the
    // button edge is dropped rather than deferred.
    always_ff @(posedge clk) begin
        if (Reset) begin
            Exp_time <= EXP_INIT;
        end else if (state == IDLE && !Start) begin
            Exp_time <= exp_step(Exp_time, inc_pulse, dec_pulse, EXP_LO, EXP_HI);
        end
    end

    logic [RO_W-1:0] ro_cnt;

    // A restart reloads the count and swallows an Ovf5 that was due now.
    always_ff @(posedge clk) begin
        if (Reset) begin
            ro_cnt <= '0;
            Ovf5   <= 1'b0;
        end else if (Start_ro) begin
            ro_cnt <= RO_LOAD;
            Ovf5   <= 1'b0;
        end else if (ro_cnt != '0) begin
            ro_cnt <= ro_cnt - 3'd1;
            Ovf5   <= (ro_cnt == 3'd1);
        end else begin
            Ovf5   <= 1'b0;
        end
    end

endmodule
